// File: rtl/scatter_control_unit.sv
// scatter_control_unit: reads a job-grid config, scatters (row, col) indices to P block
// processors, counts their results and writes a status word back to memory.
module scatter_control_unit #(
   parameter int P = 4,
   parameter int IDX_W = 8,
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32,
   parameter logic [ADDR_W-1:0] CONFIG_ADDR = ADDR_W'(0),
   parameter logic [ADDR_W-1:0] STATUS_ADDR = ADDR_W'(4)
) (
   input  logic              i_Clk,
   input  logic              i_Reset,
   input  logic              i_Data_Ready,
   input  logic              i_Grant,
   input  logic [DATA_W-1:0] i_Mem_Read_Data,
   input  logic [P-1:0]      i_Indexes_Received,
   input  logic [P-1:0]      i_Result_Ready,
   output logic              o_Grant_Request,
   output logic [ADDR_W-1:0] o_Mem_Address,
   output logic              o_Mem_Write_En,
   output logic [DATA_W-1:0] o_Mem_Write_Data,
   output logic [DATA_W-1:0] o_Config,
   output logic [IDX_W-1:0]  o_Row_Index,
   output logic [IDX_W-1:0]  o_Column_Index,
   output logic [P-1:0]      o_Indexes_Ready,
   output logic              o_Done
);
   localparam int TW = 2 * IDX_W;

   typedef enum logic [2:0] {IDLE, REQ_CONFIG, SCATTER, WAIT_RESULTS, REQ_STATUS} state_t;

   state_t            state_q, state_d;
   logic              dr_low_q, dr_low_d;
   logic [DATA_W-1:0] config_q, config_d;
   logic [IDX_W-1:0]  row_q, row_d, col_q, col_d;
   logic [TW-1:0]     disp_q, disp_d, cnt_q, cnt_d;
   logic [P-1:0]      busy_q, busy_d, rdy_q, rdy_d;
   logic              done_q, done_d;
   logic [TW-1:0]     t_cfg, t_rd, res_cnt;
   logic [P-1:0]      res_hit, ack_vec, sel;
   logic [IDX_W-1:0]  cols;

   assign cols    = config_q[IDX_W-1:0];
   assign t_cfg   = TW'(config_q[TW-1:IDX_W]) * TW'(cols);
   assign t_rd    = TW'(i_Mem_Read_Data[TW-1:IDX_W]) * TW'(i_Mem_Read_Data[IDX_W-1:0]);
   assign res_hit = busy_q & i_Result_Ready;
   assign ack_vec = rdy_q & i_Indexes_Received;

   always_comb begin
      res_cnt = '0;
      for (int i = 0; i < P; i++) res_cnt += TW'(res_hit[i]);
   end

   // lowest-numbered idle processor, one-hot
   always_comb begin
      sel = '0;
      for (int i = P - 1; i >= 0; i--) if (!busy_q[i]) sel = P'(1) << i;
   end

   always_comb begin
      state_d  = state_q;
      dr_low_d = ~i_Data_Ready;
      config_d = config_q;
      row_d    = row_q;
      col_d    = col_q;
      disp_d   = disp_q;
      cnt_d    = cnt_q;
      busy_d   = busy_q;
      rdy_d    = rdy_q;
      done_d   = 1'b0;
      if (state_q == SCATTER || state_q == WAIT_RESULTS) begin
         busy_d = busy_q & ~i_Result_Ready;
         cnt_d  = cnt_q + res_cnt;
      end
      case (state_q)
         REQ_CONFIG: if (i_Grant) begin
            config_d = i_Mem_Read_Data;
            row_d    = '0;
            col_d    = '0;
            disp_d   = '0;
            cnt_d    = '0;
            busy_d   = '0;
            rdy_d    = '0;
            state_d  = (t_rd == '0) ? REQ_STATUS : SCATTER;
         end
         SCATTER: begin
            if (|ack_vec) begin
               rdy_d   = '0;
               busy_d  = busy_d | ack_vec;
               col_d   = (col_q == cols - IDX_W'(1)) ? '0 : col_q + IDX_W'(1);
               row_d   = (col_q == cols - IDX_W'(1)) ? row_q + IDX_W'(1) : row_q;
               disp_d  = disp_q + TW'(1);
               state_d = (disp_d == t_cfg) ? WAIT_RESULTS : SCATTER;
            end else if (rdy_q == '0) begin
               rdy_d = sel;
            end
         end
         WAIT_RESULTS: if (cnt_d == t_cfg) state_d = REQ_STATUS;
         REQ_STATUS: if (i_Grant) begin
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: if (dr_low_q && i_Data_Ready) state_d = REQ_CONFIG;
      endcase
   end

   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         state_q  <= IDLE;
         dr_low_q <= 1'b0;
         config_q <= '0;
         row_q    <= '0;
         col_q    <= '0;
         disp_q   <= '0;
         cnt_q    <= '0;
         busy_q   <= '0;
         rdy_q    <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         dr_low_q <= dr_low_d;
         config_q <= config_d;
         row_q    <= row_d;
         col_q    <= col_d;
         disp_q   <= disp_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
         rdy_q    <= rdy_d;
         done_q   <= done_d;
      end
   end

   assign o_Grant_Request  = (state_q == REQ_CONFIG) || (state_q == REQ_STATUS);
   assign o_Mem_Write_En   = state_q == REQ_STATUS;
   assign o_Mem_Address    = (state_q == REQ_CONFIG) ? CONFIG_ADDR :
                             (state_q == REQ_STATUS) ? STATUS_ADDR : '0;
   assign o_Mem_Write_Data = (state_q == REQ_STATUS) ? DATA_W'({cnt_q, 1'b1}) : '0;
   assign o_Config         = config_q;
   assign o_Row_Index      = row_q;
   assign o_Column_Index   = col_q;
   assign o_Indexes_Ready  = rdy_q;
   assign o_Done           = done_q;
endmodule

// File: tb/tb_scatter_control_unit.sv
// tb_scatter_control_unit: directed checks of config fetch, index scatter, result counting,
// status write and reset behaviour.
module tb_scatter_control_unit;
   logic        clk = 1'b0;
   logic        rst;
   logic        data_ready, grant;
   logic [31:0] rd_data;
   logic [3:0]  idx_rcv, res_rdy;
   logic        req, we, done;
   logic [31:0] addr, wdata, cfg;
   logic [7:0]  row, col;
   logic [3:0]  idx_rdy;
   int          checks = 0;
   int          errors = 0;

   scatter_control_unit dut (
      .i_Clk(clk), .i_Reset(rst), .i_Data_Ready(data_ready), .i_Grant(grant),
      .i_Mem_Read_Data(rd_data), .i_Indexes_Received(idx_rcv), .i_Result_Ready(res_rdy),
      .o_Grant_Request(req), .o_Mem_Address(addr), .o_Mem_Write_En(we),
      .o_Mem_Write_Data(wdata), .o_Config(cfg), .o_Row_Index(row), .o_Column_Index(col),
      .o_Indexes_Ready(idx_rdy), .o_Done(done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic handoff(input logic [3:0] tgt, input logic [7:0] r, input logic [7:0] c,
                          input int hold, input logic [3:0] stray);
      for (int i = 0; i < 10 && idx_rdy == 4'b0; i++) tick();
      check("handoff_target", 32'(idx_rdy), 32'(tgt));
      check("handoff_row", 32'(row), 32'(r));
      check("handoff_col", 32'(col), 32'(c));
      idx_rcv = stray;
      for (int i = 0; i < hold; i++) begin
         tick();
         check("hold_ready", 32'(idx_rdy), 32'(tgt));
         check("hold_index", {16'b0, row, col}, {16'b0, r, c});
      end
      idx_rcv = tgt;
      tick();
      idx_rcv = 4'b0;
      check("ready_drop", 32'(idx_rdy), 32'h0);
   endtask

   initial begin
      rst = 1'b1; data_ready = 1'b0; grant = 1'b0; rd_data = '0; idx_rcv = '0; res_rdy = '0;
      tick(); tick();
      rst = 1'b0;
      tick();
      check("rst_req", 32'(req), 32'h0);
      check("rst_cfg", cfg, 32'h0);
      check("rst_rdy", 32'(idx_rdy), 32'h0);
      check("rst_done", 32'(done), 32'h0);
      // job set: 2 rows x 3 cols, config grant withheld 10 cycles
      data_ready = 1'b1;
      tick();
      check("cfg_req", 32'(req), 32'h1);
      check("cfg_addr", addr, 32'h0);
      check("cfg_we", 32'(we), 32'h0);
      rd_data = 32'h0000_0203;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("cfg_req_held", 32'(req), 32'h1);
         check("cfg_unchanged", cfg, 32'h0);
      end
      grant = 1'b1;
      tick();
      grant = 1'b0; rd_data = '0;
      check("cfg_latched", cfg, 32'h203);
      check("scatter_req_low", 32'(req), 32'h0);
      handoff(4'b0001, 8'd0, 8'd0, 0, 4'b0);
      res_rdy = 4'b0100;
      tick();
      res_rdy = 4'b0;
      handoff(4'b0010, 8'd0, 8'd1, 0, 4'b0);
      handoff(4'b0100, 8'd0, 8'd2, 0, 4'b0);
      handoff(4'b1000, 8'd1, 8'd0, 0, 4'b0);
      tick(); tick();
      check("stall_all_busy", 32'(idx_rdy), 32'h0);
      res_rdy = 4'b1010;
      tick();
      res_rdy = 4'b0;
      handoff(4'b0010, 8'd1, 8'd1, 0, 4'b0);
      handoff(4'b1000, 8'd1, 8'd2, 7, 4'b0001);
      tick();
      check("wait_req_low", 32'(req), 32'h0);
      check("wait_rdy_low", 32'(idx_rdy), 32'h0);
      res_rdy = 4'b1111;
      tick();
      res_rdy = 4'b0;
      check("status_req", 32'(req), 32'h1);
      check("status_we", 32'(we), 32'h1);
      check("status_addr", addr, 32'h4);
      check("status_data", wdata, 32'h0D);
      tick();
      check("status_req_held", 32'(req), 32'h1);
      check("done_before_grant", 32'(done), 32'h0);
      grant = 1'b1;
      tick();
      grant = 1'b0;
      check("done_pulse", 32'(done), 32'h1);
      check("idle_req_low", 32'(req), 32'h0);
      tick();
      check("done_single", 32'(done), 32'h0);
      tick(); tick();
      check("no_restart_level", 32'(req), 32'h0);
      // empty job set
      data_ready = 1'b0;
      tick();
      data_ready = 1'b1;
      tick();
      check("zero_cfg_req", 32'(req), 32'h1);
      grant = 1'b1;
      tick();
      grant = 1'b0;
      check("zero_status_we", 32'(we), 32'h1);
      check("zero_status_data", wdata, 32'h1);
      check("zero_no_rdy", 32'(idx_rdy), 32'h0);
      tick();
      check("zero_no_rdy2", 32'(idx_rdy), 32'h0);
      grant = 1'b1;
      tick();
      grant = 1'b0;
      check("zero_done", 32'(done), 32'h1);
      // reset in the middle of a scatter
      data_ready = 1'b0;
      tick();
      data_ready = 1'b1;
      tick();
      rd_data = 32'h0000_0203; grant = 1'b1;
      tick();
      grant = 1'b0; rd_data = '0;
      handoff(4'b0001, 8'd0, 8'd0, 0, 4'b0);
      tick();
      check("pre_rst_rdy", 32'(idx_rdy), 32'h2);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_rst_rdy", 32'(idx_rdy), 32'h0);
      check("mid_rst_cfg", cfg, 32'h0);
      check("mid_rst_index", {16'b0, row, col}, 32'h0);
      check("mid_rst_bus", {30'b0, req, we} | addr | wdata, 32'h0);
      check("mid_rst_done", 32'(done), 32'h0);
      tick(); tick(); tick();
      check("rst_level_no_start", 32'(req), 32'h0);
      data_ready = 1'b0;
      tick();
      data_ready = 1'b1;
      tick();
      check("restart_after_toggle", 32'(req), 32'h1);
      grant = 1'b1;
      tick();
      grant = 1'b0;
      tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
